gpio_bank: RTL and testbench
============================

# gpio_bank

Parametrised multi-port GPIO peripheral: the successor to the two-port I/O block on the CPU's I/O bus. It provides PORT_COUNT ports, each with:
- direction (DDR), output (PORT) and synchronised input (PIN) registers;
- AVR-style toggle-on-PIN-write;
- per-pin change masks feeding a sticky per-port interrupt flag and a single `irq` line to the control unit.

## Interface
- PORT_COUNT, 2, number of ports; legal range 1..8.
- DATA_WIDTH, 8, pins per port and bus data width.
- ADDR_WIDTH, 6, I/O address width; 64 I/O registers.
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset; one clock; reset is synchronous and active-high.
- cs  input  1  chip select for a bus access this cycle.
- we  input  1  write enable; write occurs on the clk edge while cs&&we.
- oe  input  1  output enable; the block drives data while cs&&oe&&!we, otherwise high-Z.
- address  input  ADDR_WIDTH  I/O register address.
- data  inout  DATA_WIDTH  bidirectional bus data.
- pins  inout  PORT_COUNT*DATA_WIDTH  port p occupies bits [p*DATA_WIDTH +: DATA_WIDTH].
- irq  output  1  pin-change interrupt request, level.

## Operation
Register map (offsets in the shared header):
- PIN_p at 3p. Read returns the synchronised pin level. Write toggles PORT_p bits written as 1.
- DDR_p at 3p+1. Bit=1 makes the pin an output.
- PORT_p at 3p+2. Output value.
- PCMSK_p at 0x18+p. Per-pin change enable.
- PCIFR at 0x20. Bit p = port p flag. Reads return flags; writing 1 clears a bit, writing 0 has no effect.
- PCICR at 0x21. Bit p = port p interrupt enable.
- Bits at or above PORT_COUNT in PCIFR and PCICR read 0 and are not writable.
- Unmapped addresses, and per-port addresses for p≥PORT_COUNT, read 0; writes to them are ignored.

Pin drive:
- Each pin bit is driven with the PORT bit when its DDR bit is 1, otherwise high-Z.
- PIN reflects the pad level even for outputs, after synchronisation.

Input path, per bit:
- Two-flop synchroniser s1→s2, then a history flop s3.
- change = s2 ^ s3.
- PCIFR[p] is set when |(change & PCMSK_p).

Outputs:
- irq = |(PCIFR & PCICR), combinational from registers.

Simultaneous events:
- Flag set and write-1-clear of the same PCIFR bit in one cycle: set wins and the bit stays 1.
- PIN toggle-write and PORT write to the same port cannot collide, because they are different addresses and there is one access per cycle.

Reset (synchronous, active-high):
- DDR, PORT, PCMSK, PCIFR, PCICR, s1, s2 and s3 are all cleared to 0.
- All pins are high-Z and irq=0.
- The data bus is high-Z unless a read is in progress.
- No spurious flags after reset, because PCMSK=0.
- Reset asserted mid-operation overrides any write in the same cycle.

## Timing
- Read latency 0: data is valid combinationally in the cycle with cs&&oe&&!we.
- Write latency 1: the register updates on the edge. A read in the following cycle returns the new value, and pins reflect a DDR/PORT write immediately after that edge.
- External pin edge to PIN visibility: 2 rising edges.
- External pin edge to flag and irq: PCIFR set on the 3rd rising edge after the pin change. irq is high in the same cycle as the flag.
- An input pulse shorter than one clk period may be missed. No flag is guaranteed for such pulses.
- irq stays high until software clears PCIFR or clears the PCICR bit.

## Structure
- Shared header `defines.vh` gains:
  - offsets `GPIO_PIN_OFS`, `GPIO_DDR_OFS`, `GPIO_PORT_OFS`, `GPIO_STRIDE` (3);
  - bases `GPIO_MSK_BASE` (0x18), `GPIO_IFR_ADDR` (0x20), `GPIO_ICR_ADDR` (0x21).
- Sub-module gpio_sync, generated once per port. Parameter DATA_WIDTH. Contains the s1/s2/s3 flops with synchronous reset. Outputs the synced level (s2) and the change vector.
- Address decode, registers, tri-states and flag logic live in gpio_bank.

## Test plan
- Reset with pins pulled to 0x5A: every register reads 0x00, pins are high-Z, irq=0, and PCIFR stays 0 for 10 cycles.
- Write DDR_1=0xF0 then PORT_1=0xA5: the next cycle pins[15:8] upper nibble shows 0xA, the lower nibble stays high-Z, and PORT_1 reads 0xA5. Writing PIN_1=0x81 makes PORT_1 read 0x24.
- Drive pins[7:0] from 0x00 to 0x01: PIN_0 reads 0x00 for 2 edges, then 0x01.
- With PCMSK_0=0x01 and PCICR=0x01, drive pin0 high: PCIFR=0x01 and irq=1 exactly on the 3rd edge. Writing PCIFR=0x01 drops irq the next cycle. Toggling pin1 (unmasked) sets no flag.
- A pin change that sets PCIFR[0] in the same cycle as a write of PCIFR=0x01: PCIFR stays 0x01.
- Access to address 0x30 and PIN_7 with PORT_COUNT=2: both read 0x00 and writes change no state. Reset asserted during a DDR write: DDR remains 0x00.

Source files
------------

// File: rtl/gpio_bank_pkg.sv
// Register map constants and address decode shared by the GPIO bank.
// Pure definitions: no latency, no flow control.
package gpio_bank_pkg;

    localparam int GPIO_PIN_OFS   = 0;
    localparam int GPIO_DDR_OFS   = 1;
    localparam int GPIO_PORT_OFS  = 2;
    localparam int GPIO_STRIDE    = 3;
    localparam int GPIO_MSK_BASE  = 'h18;
    localparam int GPIO_IFR_ADDR  = 'h20;
    localparam int GPIO_ICR_ADDR  = 'h21;
    localparam int GPIO_MAX_PORTS = 8;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_PIN,
        SEL_DDR,
        SEL_PORT,
        SEL_MSK,
        SEL_IFR,
        SEL_ICR
    } reg_sel_e;

    typedef struct packed {
        reg_sel_e   sel;
        logic [2:0] port;
    } decode_t;

    // Per-port addresses beyond port_count fall through to SEL_NONE.
    function automatic decode_t gpio_decode(input logic [7:0] addr, input int port_count);
        decode_t d;
        d.sel  = SEL_NONE;
        d.port = '0;
        for (int p = 0; p < GPIO_MAX_PORTS; p++) begin
            if (p < port_count) begin
                if (addr == 8'(GPIO_STRIDE * p + GPIO_PIN_OFS)) begin
                    d.sel  = SEL_PIN;
                    d.port = 3'(p);
                end
                if (addr == 8'(GPIO_STRIDE * p + GPIO_DDR_OFS)) begin
                    d.sel  = SEL_DDR;
                    d.port = 3'(p);
                end
                if (addr == 8'(GPIO_STRIDE * p + GPIO_PORT_OFS)) begin
                    d.sel  = SEL_PORT;
                    d.port = 3'(p);
                end
                if (addr == 8'(GPIO_MSK_BASE + p)) begin
                    d.sel  = SEL_MSK;
                    d.port = 3'(p);
                end
            end
        end
        if (addr == 8'(GPIO_IFR_ADDR)) d.sel = SEL_IFR;
        if (addr == 8'(GPIO_ICR_ADDR)) d.sel = SEL_ICR;
        return d;
    endfunction

endpackage

// File: rtl/gpio_bank_if.sv
// I/O bus control lines plus the interrupt line back to the control unit.
// Single access per cycle, no backpressure.
interface gpio_bank_if #(
    parameter int ADDR_WIDTH = 6
);
    logic                  cs;
    logic                  we;
    logic                  oe;
    logic [ADDR_WIDTH-1:0] address;
    logic                  irq;

    modport master (output cs, we, oe, address, input irq);
    modport slave  (input cs, we, oe, address, output irq);
endinterface

// File: rtl/gpio_sync.sv
// Two-flop pad synchroniser plus history flop; reports level (s2) and change (s2^s3).
// Pad to level: 2 edges; no backpressure.
module gpio_sync #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [DATA_WIDTH-1:0] pins_i,
    output logic [DATA_WIDTH-1:0] level_o,
    output logic [DATA_WIDTH-1:0] change_o
);
    logic [DATA_WIDTH-1:0] s1_q, s1_d;
    logic [DATA_WIDTH-1:0] s2_q, s2_d;
    logic [DATA_WIDTH-1:0] s3_q, s3_d;

    assign s1_d = pins_i;
    assign s2_d = s1_q;
    assign s3_d = s2_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign level_o  = s2_q;
    assign change_o = s2_q ^ s3_q;
endmodule

// File: rtl/gpio_bank.sv
// Multi-port GPIO: DDR/PORT/PIN per port, toggle-on-PIN-write, pin-change interrupt.
// Reads combinational, writes land on the edge; no backpressure.
module gpio_bank #(
    parameter int PORT_COUNT = 2,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                             clk,
    input  logic                             reset,
    gpio_bank_if.slave                       bus,
    inout  wire  [DATA_WIDTH-1:0]            data,
    inout  wire  [PORT_COUNT*DATA_WIDTH-1:0] pins
);
    import gpio_bank_pkg::*;

    logic [DATA_WIDTH-1:0] ddr_q   [PORT_COUNT];
    logic [DATA_WIDTH-1:0] ddr_d   [PORT_COUNT];
    logic [DATA_WIDTH-1:0] port_q  [PORT_COUNT];
    logic [DATA_WIDTH-1:0] port_d  [PORT_COUNT];
    logic [DATA_WIDTH-1:0] pcmsk_q [PORT_COUNT];
    logic [DATA_WIDTH-1:0] pcmsk_d [PORT_COUNT];
    logic [DATA_WIDTH-1:0] level   [PORT_COUNT];
    logic [DATA_WIDTH-1:0] change  [PORT_COUNT];
    logic [PORT_COUNT-1:0] pcifr_q, pcifr_d;
    logic [PORT_COUNT-1:0] pcicr_q, pcicr_d;

    decode_t               dec;
    logic                  wr_en;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_dat;
    logic [DATA_WIDTH-1:0] wr_dat;

    assign dec    = gpio_decode(8'(bus.address), PORT_COUNT);
    assign wr_en  = bus.cs && bus.we;
    assign rd_en  = bus.cs && bus.oe && !bus.we;
    assign wr_dat = data;

    for (genvar p = 0; p < PORT_COUNT; p++) begin : g_port
        gpio_sync #(.DATA_WIDTH(DATA_WIDTH)) u_sync (
            .clk_i    (clk),
            .reset_i  (reset),
            .pins_i   (pins[p*DATA_WIDTH +: DATA_WIDTH]),
            .level_o  (level[p]),
            .change_o (change[p])
        );
        for (genvar b = 0; b < DATA_WIDTH; b++) begin : g_bit
            assign pins[p*DATA_WIDTH + b] = ddr_q[p][b] ? port_q[p][b] : 1'bz;
        end
    end

    always_comb begin
        ddr_d   = ddr_q;
        port_d  = port_q;
        pcmsk_d = pcmsk_q;
        pcicr_d = pcicr_q;
        pcifr_d = pcifr_q;
        if (wr_en) begin
            for (int p = 0; p < PORT_COUNT; p++) begin
                if (dec.port == 3'(p)) begin
                    case (dec.sel)
                        SEL_PIN:  port_d[p]  = port_q[p] ^ wr_dat;
                        SEL_DDR:  ddr_d[p]   = wr_dat;
                        SEL_PORT: port_d[p]  = wr_dat;
                        SEL_MSK:  pcmsk_d[p] = wr_dat;
                        default: ;
                    endcase
                end
            end
            case (dec.sel)
                SEL_IFR: pcifr_d = pcifr_q & ~wr_dat[PORT_COUNT-1:0];
                SEL_ICR: pcicr_d = wr_dat[PORT_COUNT-1:0];
                default: ;
            endcase
        end
        // Applied after the write-1-clear so a same-cycle set wins.
        for (int p = 0; p < PORT_COUNT; p++) begin
            if (|(change[p] & pcmsk_q[p])) pcifr_d[p] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ddr_q   <= '{default: '0};
            port_q  <= '{default: '0};
            pcmsk_q <= '{default: '0};
            pcifr_q <= '0;
            pcicr_q <= '0;
        end else begin
            ddr_q   <= ddr_d;
            port_q  <= port_d;
            pcmsk_q <= pcmsk_d;
            pcifr_q <= pcifr_d;
            pcicr_q <= pcicr_d;
        end
    end

    always_comb begin
        rd_dat = '0;
        for (int p = 0; p < PORT_COUNT; p++) begin
            if (dec.port == 3'(p)) begin
                case (dec.sel)
                    SEL_PIN:  rd_dat = level[p];
                    SEL_DDR:  rd_dat = ddr_q[p];
                    SEL_PORT: rd_dat = port_q[p];
                    SEL_MSK:  rd_dat = pcmsk_q[p];
                    default: ;
                endcase
            end
        end
        case (dec.sel)
            SEL_IFR: rd_dat = DATA_WIDTH'(pcifr_q);
            SEL_ICR: rd_dat = DATA_WIDTH'(pcicr_q);
            default: ;
        endcase
    end

    assign data    = rd_en ? rd_dat : {DATA_WIDTH{1'bz}};
    assign bus.irq = |(pcifr_q & pcicr_q);
endmodule

// File: tb/tb_gpio_bank.sv
// Directed bench for gpio_bank with two 8-bit ports; expected values are hand-computed.
module tb_gpio_bank;
    logic        clk;
    logic        reset;
    logic [7:0]  tb_dat;
    logic        tb_drv_dat;
    logic [7:0]  tb_pin;
    wire  [7:0]  data_w;
    wire  [15:0] pins_w;
    int          checks;
    int          errors;
    logic [7:0]  rv;

    gpio_bank_if #(.ADDR_WIDTH(6)) bus_if ();

    assign data_w       = tb_drv_dat ? tb_dat : 8'bz;
    assign pins_w[7:0]  = tb_pin;

    gpio_bank #(.PORT_COUNT(2), .DATA_WIDTH(8), .ADDR_WIDTH(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if),
        .data  (data_w),
        .pins  (pins_w)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%02h expected 0x%02h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [5:0] a, input logic [7:0] v);
        bus_if.cs      = 1'b1;
        bus_if.we      = 1'b1;
        bus_if.oe      = 1'b0;
        bus_if.address = a;
        tb_dat         = v;
        tb_drv_dat     = 1'b1;
        step(1);
        bus_if.cs      = 1'b0;
        bus_if.we      = 1'b0;
        tb_drv_dat     = 1'b0;
    endtask

    task automatic bus_read(input logic [5:0] a, output logic [7:0] v);
        bus_if.cs      = 1'b1;
        bus_if.we      = 1'b0;
        bus_if.oe      = 1'b1;
        bus_if.address = a;
        #1;
        v              = data_w;
        bus_if.cs      = 1'b0;
        bus_if.oe      = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [5:0] a, input logic [7:0] exp);
        logic [7:0] v;
        bus_read(a, v);
        chk(tag, v, exp);
    endtask

    initial begin
        logic [5:0] reg_addrs [10];
        checks         = 0;
        errors         = 0;
        bus_if.cs      = 1'b0;
        bus_if.we      = 1'b0;
        bus_if.oe      = 1'b0;
        bus_if.address = '0;
        tb_dat         = '0;
        tb_drv_dat     = 1'b0;
        tb_pin         = 8'h5A;
        reset          = 1'b1;
        reg_addrs      = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05,
                           6'h18, 6'h19, 6'h20, 6'h21};

        // Reset with pins pulled to 0x5A
        step(3);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) rd_chk($sformatf("rst_reg_%02h", reg_addrs[i]), reg_addrs[i], 8'h00);
        chk("rst_irq", {7'd0, bus_if.irq}, 8'h00);
        chk("rst_pins0", pins_w[7:0], 8'h5A);
        for (int i = 0; i < 10; i++) begin
            step(1);
            rd_chk($sformatf("rst_pcifr_c%0d", i), 6'h20, 8'h00);
        end
        rd_chk("rst_pin0_sync", 6'h00, 8'h5A);

        // DDR_1 / PORT_1 drive and PIN toggle
        bus_write(6'h04, 8'hF0);
        bus_write(6'h05, 8'hA5);
        chk("drv_pins_hi", {4'h0, pins_w[15:12]}, 8'h0A);
        rd_chk("drv_port1", 6'h05, 8'hA5);
        rd_chk("drv_ddr1", 6'h04, 8'hF0);
        step(2);
        bus_read(6'h03, rv);
        chk("drv_pin1_hi", rv & 8'hF0, 8'hA0);
        bus_write(6'h03, 8'h81);
        rd_chk("tgl_port1", 6'h05, 8'h24);
        chk("tgl_pins_hi", {4'h0, pins_w[15:12]}, 8'h02);

        // Synchroniser latency on port 0
        tb_pin = 8'h00;
        step(4);
        tb_pin = 8'h01;
        rd_chk("sync_e0", 6'h00, 8'h00);
        step(1);
        rd_chk("sync_e1", 6'h00, 8'h00);
        step(1);
        rd_chk("sync_e2", 6'h00, 8'h01);

        // Pin-change flag on the 3rd edge
        bus_write(6'h18, 8'h01);
        bus_write(6'h21, 8'h01);
        step(3);
        rd_chk("pc_idle", 6'h20, 8'h00);
        tb_pin = 8'h00;
        step(1);
        rd_chk("pc_e1", 6'h20, 8'h00);
        step(1);
        rd_chk("pc_e2", 6'h20, 8'h00);
        chk("pc_e2_irq", {7'd0, bus_if.irq}, 8'h00);
        step(1);
        rd_chk("pc_e3", 6'h20, 8'h01);
        chk("pc_e3_irq", {7'd0, bus_if.irq}, 8'h01);
        bus_write(6'h20, 8'h01);
        chk("clr_irq", {7'd0, bus_if.irq}, 8'h00);
        rd_chk("clr_pcifr", 6'h20, 8'h00);
        tb_pin = 8'h02;
        step(5);
        rd_chk("unmask_up", 6'h20, 8'h00);
        tb_pin = 8'h00;
        step(5);
        rd_chk("unmask_dn", 6'h20, 8'h00);
        chk("unmask_irq", {7'd0, bus_if.irq}, 8'h00);

        // Flag set coincident with write-1-clear
        tb_pin = 8'h01;
        step(2);
        bus_write(6'h20, 8'h01);
        rd_chk("setwins", 6'h20, 8'h01);
        chk("setwins_irq", {7'd0, bus_if.irq}, 8'h01);
        bus_write(6'h20, 8'h01);
        rd_chk("setwins_clr", 6'h20, 8'h00);

        // Unmapped and absent-port addresses
        bus_write(6'h30, 8'hFF);
        bus_write(6'h15, 8'hFF);
        bus_write(6'h07, 8'hFF);
        bus_write(6'h1A, 8'hFF);
        rd_chk("unmap_30", 6'h30, 8'h00);
        rd_chk("unmap_pin7", 6'h15, 8'h00);
        rd_chk("unmap_ddr2", 6'h07, 8'h00);
        rd_chk("unmap_msk2", 6'h1A, 8'h00);
        rd_chk("keep_ddr1", 6'h04, 8'hF0);
        rd_chk("keep_port1", 6'h05, 8'h24);
        rd_chk("keep_msk0", 6'h18, 8'h01);
        rd_chk("keep_pcicr", 6'h21, 8'h01);
        rd_chk("keep_pcifr", 6'h20, 8'h00);
        bus_write(6'h21, 8'hFF);
        rd_chk("pcicr_hibits", 6'h21, 8'h03);

        // Reset overrides a same-cycle DDR write
        reset = 1'b1;
        bus_write(6'h01, 8'hFF);
        reset = 1'b0;
        rd_chk("rstwr_ddr0", 6'h01, 8'h00);
        rd_chk("rstwr_ddr1", 6'h04, 8'h00);
        rd_chk("rstwr_port1", 6'h05, 8'h00);
        rd_chk("rstwr_pcicr", 6'h21, 8'h00);
        chk("rstwr_irq", {7'd0, bus_if.irq}, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
